// File: rtl/bus_decoder.sv
// ---------------------------------------------------------------------------
// bus_decoder
//
// Decodes a CPU memory bus into NREG region chip selects. Each region can add
// a fixed number of wait states. A separate write-only I/O latch is also
// decoded at a single address.
//
// Handshake: a bus cycle runs for as long as cpu_mreq_n is held low. The
// region is decoded once, on the first rising edge that sees cpu_mreq_n low.
// wait_n=0 tells the CPU to stretch the cycle. The cycle ends on the first
// rising edge that sees cpu_mreq_n high again.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   asynchronous, active-high reset
//   cpu_mreq_n   in   memory request, active low
//   cpu_rd_n     in   read strobe, active low
//   cpu_wr_n     in   write strobe, active low
//   cpu_addr     in   [ADDR_W] address
//   cpu_din      in   [DATA_W] CPU write data
//   region_dout  in   [NREG*DATA_W] packed region read data, region 0 in LSBs
//   cs_n         out  [NREG] registered chip selects, active low
//   wait_n       out  registered CPU wait request, active low
//   write_n      out  qualified write strobe, active low
//   dout         out  [DATA_W] read data to the CPU
//   latch_q      out  [DATA_W] I/O latch contents
// ---------------------------------------------------------------------------
module bus_decoder #(
    parameter int                       ADDR_W     = 16,
    parameter int                       DATA_W     = 8,
    parameter int                       NREG       = 4,
    parameter logic [NREG*ADDR_W-1:0]   REG_BASE   = {16'h4000, 16'h0000, 16'h3C00, 16'h3800},
    parameter logic [NREG*ADDR_W-1:0]   REG_MASK   = {16'hC000, 16'hC000, 16'hFC00, 16'hFC00},
    parameter logic [NREG*4-1:0]        REG_WAIT   = {4'd0, 4'd2, 4'd1, 4'd0},
    parameter logic [ADDR_W-1:0]        LATCH_ADDR = 16'h37E0,
    parameter logic [DATA_W-1:0]        OPEN_BUS   = 8'hFF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_mreq_n,
    input  logic                     cpu_rd_n,
    input  logic                     cpu_wr_n,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_din,
    input  logic [NREG*DATA_W-1:0]   region_dout,
    output logic [NREG-1:0]          cs_n,
    output logic                     wait_n,
    output logic                     write_n,
    output logic [DATA_W-1:0]        dout,
    output logic [DATA_W-1:0]        latch_q
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NREG-1:0]     cs_n_q, cs_n_d;
    logic                wait_n_q, wait_n_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   latch_data_q, latch_data_d;
    logic                latch_done_q, latch_done_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [3:0]          hit_wait;
    logic [DATA_W-1:0]   rd_slice;

    // Address decode. Scanning from the top index down lets the lowest
    // matching region overwrite the others, so the lowest index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_wait = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((cpu_addr & REG_MASK[i*ADDR_W +: ADDR_W]) == REG_BASE[i*ADDR_W +: ADDR_W]) begin
                hit      = 1'b1;
                hit_idx  = i[IDX_W-1:0];
                hit_wait = REG_WAIT[i*4 +: 4];
            end
        end
    end

    // Bus-cycle FSM: next state and registered outputs.
    always_comb begin
        state_d  = state_q;
        cs_n_d   = cs_n_q;
        wait_n_d = wait_n_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (!cpu_mreq_n) begin
                    if (hit) begin
                        sel_d           = hit_idx;
                        cs_n_d          = '1;
                        cs_n_d[hit_idx] = 1'b0;
                        if (hit_wait != 4'd0) begin
                            state_d  = ST_WAIT;
                            cnt_d    = hit_wait;
                            wait_n_d = 1'b0;
                        end else begin
                            state_d  = ST_ACCESS;
                            wait_n_d = 1'b1;
                        end
                    end else begin
                        state_d  = ST_HOLD;
                        cs_n_d   = '1;
                        wait_n_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cpu_mreq_n) begin
                    // CPU abandoned the cycle while stretched.
                    state_d  = ST_IDLE;
                    cs_n_d   = '1;
                    wait_n_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q <= 4'd1) begin
                    // Last wait cycle: wait_n was low for exactly the loaded count.
                    state_d  = ST_ACCESS;
                    wait_n_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                wait_n_d = 1'b1;
                if (cpu_mreq_n) begin
                    state_d = ST_IDLE;
                    cs_n_d  = '1;
                end
            end
            ST_HOLD: begin
                if (cpu_mreq_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cs_n_d   = '1;
                wait_n_d = 1'b1;
                cnt_d    = '0;
            end
        endcase
    end

    // I/O latch. This is independent of the region FSM. The done flag makes
    // only the first qualifying edge of a bus cycle capture, even if the write
    // strobe stays low across several edges.
    always_comb begin
        latch_data_d = latch_data_q;
        latch_done_d = latch_done_q;
        if (cpu_mreq_n) begin
            latch_done_d = 1'b0;
        end else if (!cpu_wr_n && (cpu_addr == LATCH_ADDR) && !latch_done_q) begin
            latch_data_d = cpu_din;
            latch_done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cs_n_q       <= '1;
            wait_n_q     <= 1'b1;
            cnt_q        <= '0;
            sel_q        <= '0;
            latch_data_q <= '0;
            latch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_n_q       <= cs_n_d;
            wait_n_q     <= wait_n_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            latch_data_q <= latch_data_d;
            latch_done_q <= latch_done_d;
        end
    end

    // Read data of the region latched for the current cycle.
    always_comb begin
        rd_slice = OPEN_BUS;
        for (int i = 0; i < NREG; i++) begin
            if (sel_q == i[IDX_W-1:0]) begin
                rd_slice = region_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    // dout and write_n depend on state_q, so reset forces them to their idle
    // values immediately, without waiting for a clock edge.
    assign dout    = (((state_q == ST_WAIT) || (state_q == ST_ACCESS)) && !cpu_rd_n) ? rd_slice : OPEN_BUS;
    assign write_n = !((state_q == ST_ACCESS) && !cpu_wr_n);
    assign cs_n    = cs_n_q;
    assign wait_n  = wait_n_q;
    assign latch_q = latch_data_q;

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 16, CPU address width.
REQ-002 SHALL have parameter DATA_W, 8, data width.
REQ-003 SHALL have parameter NREG, 4, number of decoded regions (1..8).
REQ-004 SHALL have parameter REG_BASE, {16'h4000,16'h0000,16'h3C00,16'h3800}, packed region bases, region 0 in LSBs.
REQ-005 SHALL have parameter REG_MASK, {16'hC000,16'hC000,16'hFC00,16'hFC00}, packed region masks.
REQ-006 SHALL have parameter REG_WAIT, {4'd0,4'd2,4'd1,4'd0}, packed per-region wait states (0..15).
REQ-007 SHALL have parameter LATCH_ADDR, 16'h37E0, write-only I/O latch address.
REQ-008 SHALL have parameter OPEN_BUS, 8'hFF, read value when nothing is selected.
REQ-009 SHALL have ports (name, direction, width, meaning): clock, in, 1, sole clock, rising edge.
REQ-010 SHALL have port reset, in, 1, asynchronous, active-high reset.
REQ-011 SHALL have port cpu_mreq_n, in, 1, memory request, active low.
REQ-012 SHALL have port cpu_rd_n, in, 1, read strobe, active low.
REQ-013 SHALL have port cpu_wr_n, in, 1, write strobe, active low.
REQ-014 SHALL have port cpu_addr, in, ADDR_W, address.
REQ-015 SHALL have port cpu_din, in, DATA_W, CPU write data.
REQ-016 SHALL have port region_dout, in, NREG*DATA_W, packed region read data.
REQ-017 SHALL have port cs_n, out, NREG, registered chip selects, active low.
REQ-018 SHALL have port wait_n, out, 1, CPU wait request, active low.
REQ-019 SHALL have port write_n, out, 1, qualified write strobe, active low.
REQ-020 SHALL have port dout, out, DATA_W, read data to CPU.
REQ-021 SHALL have port latch_q, out, DATA_W, I/O latch contents.

Function
REQ-022 SHALL detect a region hit when (cpu_addr & REG_MASK[i]) == REG_BASE[i].
REQ-023 SHALL resolve multiple hits by lowest index; exactly one cs_n bit is low at most.
REQ-024 SHALL implement FSM states IDLE, WAIT, ACCESS, HOLD.
REQ-025 In IDLE with cpu_mreq_n=0 and a hit: SHALL latch the region index, drive that cs_n bit low on the next edge, and enter WAIT if REG_WAIT>0, else ACCESS.
REQ-026 In IDLE with cpu_mreq_n=0 and no hit: SHALL enter HOLD with all cs_n high.
REQ-027 WAIT SHALL hold wait_n=0 for exactly REG_WAIT[i] cycles, counted by a down-counter loaded on entry, then enter ACCESS.
REQ-028 ACCESS SHALL hold cs_n, with wait_n=1, until cpu_mreq_n=1, then enter IDLE and release cs_n on that edge.
REQ-029 HOLD SHALL return to IDLE on the edge where cpu_mreq_n=1.
REQ-030 If cpu_mreq_n rises during WAIT (abort), SHALL enter IDLE next edge, with cs_n all high and wait_n=1.
REQ-031 write_n SHALL be 0 only in ACCESS with cpu_wr_n=0; it SHALL be 1 in WAIT, HOLD and IDLE.
REQ-032 dout SHALL be the selected region's slice of region_dout when in ACCESS or WAIT with cpu_rd_n=0; otherwise it SHALL be OPEN_BUS.
REQ-033 latch_q SHALL capture cpu_din once per bus cycle, on the first edge with cpu_mreq_n=0, cpu_wr_n=0 and cpu_addr==LATCH_ADDR.
REQ-034 Latch capture SHALL be independent of the region decode, and a one-shot flag SHALL clear when cpu_mreq_n=1.
REQ-035 wait_n SHALL be registered, with no combinational path from cpu_addr.

Reset
REQ-036 On reset=1 (async), SHALL set state to IDLE, cs_n all 1, wait_n=1, write_n=1, latch_q=0, counter=0, one-shot flag clear.
REQ-037 SHALL return dout to OPEN_BUS immediately on reset, including mid-WAIT.
REQ-038 SHALL decode a new cycle on the first edge after reset deasserts if cpu_mreq_n=0.

Verification
REQ-039 Read 16'h3801, mreq low 4 cycles, region_dout[7:0]=8'h5A -> cs_n=4'b1110 one edge after mreq, wait_n stays 1, dout=8'h5A.
REQ-040 Read 16'h1234 -> cs_n=4'b1011, wait_n=0 for exactly 2 cycles, then ACCESS, dout=region 2 data.
REQ-041 Read 16'h3000 (ROM hit) vs 16'h3C00 (region 1 hit, one wait cycle); a default unmapped address, e.g. mask region 3 off, -> cs_n=4'hF, dout=8'hFF, state HOLD until mreq high.
REQ-042 Write 8'hA5 to 16'h37E0 with wr held 3 cycles and cpu_din changing to 8'h00 after 1 cycle -> latch_q=8'hA5, write_n low in ACCESS only.
REQ-043 Read 16'h0000, raise mreq after 1 wait cycle -> IDLE next edge, cs_n=4'hF, wait_n=1.
REQ-044 Reset asserted mid-WAIT -> cs_n=4'hF, wait_n=1, latch_q=0 asynchronously, before the next clock edge.
